hdmi_fifo_wr_arb: RTL and testbench



---
 rtl/hdmi_pkg.sv | 12 +
 rtl/hdmi_fifo_wr_arb_rr_arb2.sv | 15 +
 rtl/hdmi_fifo_wr_arb.sv | 110 +++++++++++
 tb/tb_hdmi_fifo_wr_arb.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
// Shared constants and state encoding for the HDMI pixel FIFO write side.
// Imported by the write-port arbiter and its round-robin helper.
package hdmi_pkg;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 1024;
  localparam int AF_THRESH  = 1020;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;
endpackage

// File: rtl/hdmi_fifo_wr_arb_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins outright,
// a tie goes to the requester named by rr_ptr.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = req;
    unique case (1'b1)
      (req == 2'b11): gnt = rr_ptr ? 2'b10 : 2'b01;
      default:        gnt = req;
    endcase
  end
endmodule

// File: rtl/hdmi_fifo_wr_arb.sv
// Packet-granular two-requester write-port arbiter for the HDMI pixel FIFO.
// Whole lines are granted round-robin; over-length lines are cut and flagged.
module hdmi_fifo_wr_arb #(
  parameter int DATA_W        = hdmi_pkg::DATA_W,
  parameter int MAX_PKT_WORDS = 1024,
  parameter int CNT_W         = 11
) (
  input  logic              wr_clk,
  input  logic              wr_rst_n,
  input  logic              s0_valid,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_last,
  output logic              s0_ready,
  input  logic              s1_valid,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_last,
  output logic              s1_ready,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  input  logic              fifo_wr_full,
  input  logic              fifo_almost_full,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              err_trunc,
  input  logic              err_clr
);
  import hdmi_pkg::*;

  state_e             state_q, state_d;
  logic [1:0]         grant_q, grant_d, pick;
  logic               rr_ptr_q;
  logic [CNT_W-1:0]   word_cnt_q;
  logic               xfer, last_sel, cnt_hit, release_pkt;
  logic [DATA_W-1:0]  data_sel;

  rr_arb2 u_rr_arb2 (
    .req    ({s1_valid, s0_valid}),
    .rr_ptr (rr_ptr_q),
    .gnt    (pick)
  );

  assign xfer     = (s0_valid & s0_ready) | (s1_valid & s1_ready);
  assign data_sel = grant_q[1] ? s1_data : s0_data;
  assign last_sel = grant_q[1] ? s1_last : s0_last;
  assign cnt_hit  = (word_cnt_q + CNT_W'(1)) == CNT_W'(MAX_PKT_WORDS);
  assign release_pkt = xfer & (last_sel | cnt_hit);

  always_ff @(posedge wr_clk) begin
    if (!wr_rst_n) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: begin
        if (|pick) begin
          state_d = XFER;
          grant_d = pick;
        end
      end
      XFER: begin
        if (release_pkt) begin
          state_d = IDLE;
          grant_d = 2'b00;
        end
      end
    endcase
  end

  // Ready is masked during reset so no word is taken while aborting.
  always_comb begin
    s0_ready = 1'b0;
    s1_ready = 1'b0;
    busy     = (state_q == XFER);
    grant    = grant_q;
    if (wr_rst_n && state_q == XFER &&
        !fifo_almost_full && !fifo_wr_full) begin
      s0_ready = grant_q[0];
      s1_ready = grant_q[1];
    end
  end

  always_ff @(posedge wr_clk) begin
    if (!wr_rst_n) begin
      rr_ptr_q     <= 1'b0;
      word_cnt_q   <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      err_trunc    <= 1'b0;
    end else begin
      fifo_wr_en <= xfer;
      if (xfer) fifo_wr_data <= data_sel;
      if (release_pkt) begin
        word_cnt_q <= '0;
        rr_ptr_q   <= grant_q[0];
      end else if (xfer) begin
        word_cnt_q <= word_cnt_q + CNT_W'(1);
      end
      if (xfer & cnt_hit & ~last_sel) err_trunc <= 1'b1;
      else if (err_clr)               err_trunc <= 1'b0;
    end
  end
endmodule

// File: tb/tb_hdmi_fifo_wr_arb.sv
// Self-checking bench for hdmi_fifo_wr_arb: directed scenarios with random
// data, gaps and FIFO throttling, checked against a packet-order model.
module tb_hdmi_fifo_wr_arb;
  logic        clk = 1'b0;
  logic        wr_rst_n = 1'b0;
  logic        s0_valid = 1'b0, s0_last = 1'b0, s1_valid = 1'b0, s1_last = 1'b0;
  logic [31:0] s0_data = '0, s1_data = '0;
  logic        s0_ready, s1_ready;
  logic        fifo_wr_en;
  logic [31:0] fifo_wr_data;
  logic        fifo_wr_full = 1'b0, fifo_almost_full = 1'b0;
  logic [1:0]  grant;
  logic        busy, err_trunc;
  logic        err_clr = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic full_q = 1'b0;
  logic [31:0] got[$];
  int          got_cyc[$];
  logic [31:0] exp_q[$];

  hdmi_fifo_wr_arb #(.DATA_W(32), .MAX_PKT_WORDS(16), .CNT_W(11)) dut (
    .wr_clk(clk), .wr_rst_n(wr_rst_n),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_last(s0_last), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_last(s1_last), .s1_ready(s1_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .fifo_wr_full(fifo_wr_full), .fifo_almost_full(fifo_almost_full),
    .grant(grant), .busy(busy), .err_trunc(err_trunc), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    full_q <= fifo_wr_full;
  end

  always @(negedge clk) begin
    if (fifo_wr_en) begin
      got.push_back(fifo_wr_data);
      got_cyc.push_back(cyc);
    end
    if (full_q) chk("no_wr_after_full", {31'b0, fifo_wr_en}, 32'd0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    wr_rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 wr_rst_n = 1'b1;
  endtask

  task automatic push_word(input int id, input logic [31:0] d, input bit l);
    bit acc;
    int n;
    if (id == 0) begin s0_valid = 1'b1; s0_data = d; s0_last = l; end
    else         begin s1_valid = 1'b1; s1_data = d; s1_last = l; end
    acc = 1'b0;
    n = 0;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = (id == 0) ? s0_ready : s1_ready;
      @(posedge clk);
      #1 n++;
    end
    chk("accept", {31'b0, acc}, 32'd1);
  endtask

  task automatic go_idle(input int id);
    if (id == 0) begin s0_valid = 1'b0; s0_last = 1'b0; end
    else         begin s1_valid = 1'b0; s1_last = 1'b0; end
  endtask

  task automatic send_pkt(input int id, input logic [31:0] base, input int n,
                          input bit with_last, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0 && $urandom_range(0, 3) == 0) begin
        go_idle(id);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      push_word(id, base + 32'(i), with_last && (i == n - 1));
    end
    go_idle(id);
  endtask

  task automatic cmp_got(input string tag);
    chk({tag, "_len"}, got.size(), exp_q.size());
    foreach (exp_q[i])
      chk(tag, (i < got.size()) ? got[i] : 32'hxxxx_xxxx, exp_q[i]);
  endtask

  initial begin
    logic [31:0] b[2][2];
    int c0, n, w, ptr;
    int k[2];
    bit stop;

    do_reset();
    @(negedge clk);
    chk("rst_grant", {30'b0, grant}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_wr_en", {31'b0, fifo_wr_en}, 32'd0);
    chk("rst_wr_data", fifo_wr_data, 32'd0);
    chk("rst_err", {31'b0, err_trunc}, 32'd0);
    chk("rst_ready", {30'b0, s1_ready, s0_ready}, 32'd0);

    // Single packet with exact cycle timing.
    @(posedge clk);
    #1 got.delete();
    got_cyc.delete();
    c0 = cyc;
    fork
      send_pkt(0, 32'h100, 8, 1'b1, 1'b0);
      begin
        @(negedge clk);
        chk("A_grant_arb", {30'b0, grant}, 32'd0);
        chk("A_ready_arb", {31'b0, s0_ready}, 32'd0);
        @(negedge clk);
        chk("A_grant", {30'b0, grant}, 32'd1);
        chk("A_busy", {31'b0, busy}, 32'd1);
      end
    join
    @(negedge clk);
    chk("A_grant_rel", {30'b0, grant}, 32'd0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h100 + 32'(i));
    cmp_got("A_data");
    for (int i = 0; i < 8; i++)
      chk("A_cycle", (i < got_cyc.size()) ? got_cyc[i] : -1, c0 + 2 + i);

    // Two requesters, two packets each, random gaps and FIFO throttling.
    do_reset();
    got.delete();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < 2; p++) b[r][p] = $urandom & 32'hFFFF_FF00;
    exp_q.delete();
    ptr = 0;
    k = '{0, 0};
    while (k[0] < 2 || k[1] < 2) begin
      if (k[0] < 2 && k[1] < 2) w = ptr;
      else w = (k[0] < 2) ? 0 : 1;
      for (int i = 0; i < 4; i++) exp_q.push_back(b[w][k[w]] + 32'(i));
      k[w]++;
      ptr = 1 - w;
    end
    stop = 1'b0;
    fork
      begin
        fork
          begin
            send_pkt(0, b[0][0], 4, 1'b1, 1'b1);
            send_pkt(0, b[0][1], 4, 1'b1, 1'b1);
          end
          begin
            send_pkt(1, b[1][0], 4, 1'b1, 1'b1);
            send_pkt(1, b[1][1], 4, 1'b1, 1'b1);
          end
        join
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(posedge clk);
          #1 fifo_almost_full = ($urandom_range(0, 3) == 0);
          fifo_wr_full = ($urandom_range(0, 15) == 0);
        end
        fifo_almost_full = 1'b0;
        fifo_wr_full = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    cmp_got("B_order");
    chk("B_grant_end", {30'b0, grant}, 32'd0);

    // Backpressure window mid-packet.
    @(posedge clk);
    #1 got.delete();
    fork
      send_pkt(0, 32'h200, 16, 1'b1, 1'b0);
      begin
        n = 0;
        while (got.size() < 5 && n < 100) begin
          @(negedge clk);
          #1 n++;
        end
        @(posedge clk);
        #1 fifo_almost_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("C_ready_af", {31'b0, s0_ready}, 32'd0);
          if (i > 0) chk("C_wr_en_af", {31'b0, fifo_wr_en}, 32'd0);
          @(posedge clk);
          #1;
        end
        fifo_almost_full = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(32'h200 + 32'(i));
    cmp_got("C_data");
    chk("C_no_err", {31'b0, err_trunc}, 32'd0);

    // Over-length packet on requester 1.
    @(posedge clk);
    #1 got.delete();
    fork
      send_pkt(1, 32'h300, 20, 1'b0, 1'b0);
      begin
        n = 0;
        while (got.size() < 16 && n < 400) begin
          @(negedge clk);
          #1 n++;
        end
        chk("D_cut_len", got.size(), 32'd16);
        chk("D_cut_grant", {30'b0, grant}, 32'd0);
        chk("D_cut_busy", {31'b0, busy}, 32'd0);
        chk("D_cut_err", {31'b0, err_trunc}, 32'd1);
      end
    join
    repeat (3) @(negedge clk);
    exp_q.delete();
    for (int i = 0; i < 20; i++) exp_q.push_back(32'h300 + 32'(i));
    cmp_got("D_data");
    chk("D_regrant", {30'b0, grant}, 32'd2);
    chk("D_err_sticky", {31'b0, err_trunc}, 32'd1);
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
    chk("D_err_clr", {31'b0, err_trunc}, 32'd0);

    // Reset in the middle of a packet.
    do_reset();
    got.delete();
    for (int i = 0; i < 3; i++) push_word(0, 32'h400 + 32'(i), 1'b0);
    s0_data = 32'h403;
    wr_rst_n = 1'b0;
    @(negedge clk);
    chk("E_ready_in_rst", {31'b0, s0_ready}, 32'd0);
    @(posedge clk);
    #1 wr_rst_n = 1'b1;
    s0_valid = 1'b0;
    @(negedge clk);
    chk("E_grant", {30'b0, grant}, 32'd0);
    chk("E_busy", {31'b0, busy}, 32'd0);
    chk("E_wr_en", {31'b0, fifo_wr_en}, 32'd0);
    chk("E_wr_data", fifo_wr_data, 32'd0);
    chk("E_err", {31'b0, err_trunc}, 32'd0);
    chk("E_ready", {30'b0, s1_ready, s0_ready}, 32'd0);
    chk("E_written", got.size(), 32'd3);
    @(posedge clk);
    #1 got.delete();
    send_pkt(0, 32'h500, 8, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h500 + 32'(i));
    cmp_got("E_fresh");
    chk("E_grant_end", {30'b0, grant}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
